sdram_arbiter: RTL

Time-shares the single SDRAM controller command port between three requesters: camera write bursts, VGA read bursts and auto-refresh. Sits between the camera/VGA FIFOs, the triple-buffer bank switching logic and the SDRAM controller, all in the 133 MHz domain. Generates per-stream frame address counters and prefixes each burst address with the current camera or VGA bank.

---
 rtl/sdram_arb_pkg.sv | 19 +
 rtl/frame_addr_cnt.sv | 67 ++++++
 rtl/sdram_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared command codes, state encoding and default geometry for sdram_arbiter
package sdram_arb_pkg;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_RD   = 2'b10;
  localparam logic [1:0] CMD_REF  = 2'b11;

  localparam int DEF_BURST_LEN   = 256;
  localparam int DEF_FRAME_WORDS = 307200;
  localparam int DEF_OFS_W       = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_BUSY  = 2'b10
  } state_e;

endpackage

// File: rtl/frame_addr_cnt.sv
// rtl/frame_addr_cnt.sv - per-stream frame word offset with end-of-frame mask and deferred frame restart
module frame_addr_cnt
  import sdram_arb_pkg::*;
#(
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int OFS_W       = DEF_OFS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             advance,
  input  logic             in_flight,
  output logic [OFS_W-1:0] ofs,
  output logic             done
);

  // One extra bit so ofs + BURST_LEN can reach FRAME_WORDS without wrapping.
  localparam logic [OFS_W:0] STEP  = (OFS_W+1)'(BURST_LEN);
  localparam logic [OFS_W:0] FRAME = (OFS_W+1)'(FRAME_WORDS);

  logic [OFS_W:0] ofs_q, ofs_d;
  logic           done_q, done_d;
  logic           pend_q, pend_d;

  // Advance on burst completion, or restart; a restart during our own burst waits for its completion.
  always_comb begin
    ofs_d  = ofs_q;
    done_d = done_q;
    pend_d = pend_q;
    if (advance) begin
      if (pend_q || frame_start) begin
        ofs_d  = '0;
        done_d = 1'b0;
        pend_d = 1'b0;
      end else begin
        ofs_d  = ofs_q + STEP;
        done_d = (ofs_d >= FRAME);
      end
    end else if (frame_start) begin
      if (in_flight) begin
        pend_d = 1'b1;
      end else begin
        ofs_d  = '0;
        done_d = 1'b0;
        pend_d = 1'b0;
      end
    end
  end

  // Offset, done and pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofs_q  <= '0;
      done_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      ofs_q  <= ofs_d;
      done_q <= done_d;
      pend_q <= pend_d;
    end
  end

  assign ofs  = ofs_q[OFS_W-1:0];
  assign done = done_q;

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - refresh/camera/VGA arbiter for the SDRAM command port; optional SDRAM_ARB_PERF_EN read-wait monitor
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int OFS_W       = DEF_OFS_W
) (
  input  logic               clk,
  input  logic               rst_133,
  input  logic               ref_req,
  input  logic               wr_req,
  input  logic               rd_req,
  input  logic               cam_frame_start,
  input  logic               vga_frame_start,
  input  logic [1:0]         cam_bank,
  input  logic [1:0]         vga_bank,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_type,
  output logic [OFS_W+1:0]   cmd_addr,
  input  logic               cmd_done,
  output logic               ref_ack,
  output logic               wr_ack,
  output logic               rd_ack,
  output logic               busy
`ifdef SDRAM_ARB_PERF_EN
  ,
  output logic [15:0]        perf_rd_wait_max
`endif
);

  state_e             state_q, state_d;
  logic [1:0]         type_q, type_d;
  logic [OFS_W+1:0]   addr_q, addr_d;
  logic               last_wr_q, last_wr_d;
  logic               ref_ack_q, ref_ack_d;
  logic               wr_ack_q, wr_ack_d;
  logic               rd_ack_q, rd_ack_d;

  logic [OFS_W-1:0]   wr_ofs, rd_ofs;
  logic               wr_done, rd_done;
  logic               wr_ok, rd_ok, sel_wr, sel_rd;
  logic               wr_in_flight, rd_in_flight;
  logic               burst_end;

  // Requests from a stream that has finished its frame are ignored until its next frame start.
  assign wr_ok  = wr_req & ~wr_done;
  assign rd_ok  = rd_req & ~rd_done;
  assign sel_rd = ~ref_req & rd_ok & (~wr_ok | last_wr_q);
  assign sel_wr = ~ref_req & wr_ok & ~sel_rd;

  assign wr_in_flight = (state_q != ST_IDLE) && (type_q == CMD_WR);
  assign rd_in_flight = (state_q != ST_IDLE) && (type_q == CMD_RD);
  assign burst_end    = (state_q == ST_BUSY) && cmd_done;

  frame_addr_cnt #(
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .OFS_W       (OFS_W)
  ) u_wr_cnt (
    .clk         (clk),
    .rst_n       (rst_133),
    .frame_start (cam_frame_start),
    .advance     (burst_end && (type_q == CMD_WR)),
    .in_flight   (wr_in_flight),
    .ofs         (wr_ofs),
    .done        (wr_done)
  );

  frame_addr_cnt #(
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .OFS_W       (OFS_W)
  ) u_rd_cnt (
    .clk         (clk),
    .rst_n       (rst_133),
    .frame_start (vga_frame_start),
    .advance     (burst_end && (type_q == CMD_RD)),
    .in_flight   (rd_in_flight),
    .ofs         (rd_ofs),
    .done        (rd_done)
  );

  // IDLE picks and latches a command, ISSUE holds it for the handshake, BUSY waits for completion.
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    addr_d    = addr_q;
    last_wr_d = last_wr_q;
    ref_ack_d = 1'b0;
    wr_ack_d  = 1'b0;
    rd_ack_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ref_req) begin
          type_d  = CMD_REF;
          addr_d  = '0;
          state_d = ST_ISSUE;
        end else if (sel_rd) begin
          type_d  = CMD_RD;
          addr_d  = {vga_bank, rd_ofs};
          state_d = ST_ISSUE;
        end else if (sel_wr) begin
          type_d  = CMD_WR;
          addr_d  = {cam_bank, wr_ofs};
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (cmd_done) begin
          state_d   = ST_IDLE;
          type_d    = CMD_NONE;
          ref_ack_d = (type_q == CMD_REF);
          wr_ack_d  = (type_q == CMD_WR);
          rd_ack_d  = (type_q == CMD_RD);
          if (type_q == CMD_WR) last_wr_d = 1'b1;
          if (type_q == CMD_RD) last_wr_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state, latched command and ack pulses.
  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      state_q   <= ST_IDLE;
      type_q    <= CMD_NONE;
      addr_q    <= '0;
      last_wr_q <= 1'b1;
      ref_ack_q <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      last_wr_q <= last_wr_d;
      ref_ack_q <= ref_ack_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
    end
  end

  assign cmd_valid = (state_q == ST_ISSUE);
  assign cmd_type  = type_q;
  assign cmd_addr  = addr_q;
  assign ref_ack   = ref_ack_q;
  assign wr_ack    = wr_ack_q;
  assign rd_ack    = rd_ack_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef SDRAM_ARB_PERF_EN
  logic [15:0] rd_wait_q, rd_wait_d;
  logic [15:0] perf_max_q, perf_max_d;
  logic        rd_taken;

  assign rd_taken = (state_q == ST_IDLE) && sel_rd;

  // Count cycles a read request waits before being latched; keep the worst case per VGA frame.
  always_comb begin
    rd_wait_d  = rd_wait_q;
    perf_max_d = perf_max_q;
    if (rd_taken) begin
      if (rd_wait_q > perf_max_q) perf_max_d = rd_wait_q;
      rd_wait_d = '0;
    end else if (!rd_req) begin
      rd_wait_d = '0;
    end else if (!rd_in_flight && (rd_wait_q != 16'hFFFF)) begin
      rd_wait_d = rd_wait_q + 16'd1;
    end
    if (vga_frame_start) perf_max_d = '0;
  end

  // Read-wait monitor registers.
  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      rd_wait_q  <= '0;
      perf_max_q <= '0;
    end else begin
      rd_wait_q  <= rd_wait_d;
      perf_max_q <= perf_max_d;
    end
  end

  assign perf_rd_wait_max = perf_max_q;
`endif

endmodule
